fpu_ss_scoreboard: RTL and testbench

FP register scoreboard for the FPU subsystem. It tracks which floating-point registers have a result still outstanding from the FPU or a pending load. It blocks issue of any instruction that has a RAW or WAW hazard against those registers. It sits between the instruction buffer pop stage and the FPU/memory issue logic, and retires entries on FP register-file writebacks.

---
 rtl/fpu_ss_scoreboard.sv | 61 ++++++
 tb/tb_fpu_ss_scoreboard.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fpu_ss_scoreboard.sv
// fpu_ss_scoreboard: FP register pending-write tracker that blocks RAW/WAW-hazarded
// issue and retires entries on FP register-file writebacks.
module fpu_ss_scoreboard #(
  parameter int NUM_FPR      = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1),
  parameter int AW           = $clog2(NUM_FPR)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [AW-1:0]      rs1_i,
  input  logic [AW-1:0]      rs2_i,
  input  logic [AW-1:0]      rs3_i,
  input  logic [2:0]         rs_used_i,
  input  logic [AW-1:0]      rd_i,
  input  logic               rd_is_fp_i,
  input  logic               wb_valid_i,
  input  logic [AW-1:0]      wb_rd_i,
  input  logic               flush_i,
  output logic [NUM_FPR-1:0] busy_o,
  output logic [CNT_W-1:0]   inflight_cnt_o,
  output logic               hazard_o,
  output logic               spurious_wb_o
);
  logic [NUM_FPR-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               spurious_q, spurious_d;
  logic               raw, waw, full, set, clr;
  always_comb begin
    raw           = |(rs_used_i & {busy_q[rs3_i], busy_q[rs2_i], busy_q[rs1_i]});
    waw           = rd_is_fp_i & busy_q[rd_i];
    full          = (cnt_q == CNT_W'(MAX_INFLIGHT)) & rd_is_fp_i;
    issue_ready_o = ~raw & ~waw & ~full & ~flush_i;
    hazard_o      = issue_valid_i & (raw | waw);
    set           = issue_valid_i & issue_ready_o & rd_is_fp_i;
    clr           = wb_valid_i & busy_q[wb_rd_i];
    // Set is applied after clear so an issue to the same register wins.
    busy_d        = flush_i ? '0 :
                    (busy_q & ~(NUM_FPR'(clr) << wb_rd_i)) | (NUM_FPR'(set) << rd_i);
    cnt_d         = flush_i ? '0 :
                    (set & ~clr & (cnt_q != CNT_W'(MAX_INFLIGHT))) ? cnt_q + 1'b1 :
                    (clr & ~set & (cnt_q != '0)) ? cnt_q - 1'b1 : cnt_q;
    spurious_d    = spurious_q | (wb_valid_i & ~busy_q[wb_rd_i] & ~flush_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      cnt_q      <= '0;
      spurious_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      spurious_q <= spurious_d;
    end
  end
  assign busy_o         = busy_q;
  assign inflight_cnt_o = cnt_q;
  assign spurious_wb_o  = spurious_q;
endmodule

// File: tb/tb_fpu_ss_scoreboard.sv
// tb_fpu_ss_scoreboard: directed scoreboard bench; expected post-edge state is queued
// when a head is presented and compared once the clock edge has produced it.
module tb_fpu_ss_scoreboard;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_valid, issue_ready, rd_is_fp, wb_valid, flush, hazard, spurious;
  logic [4:0]  rs1, rs2, rs3, rd, wb_rd;
  logic [2:0]  rs_used, cnt;
  logic [31:0] busy;
  int          checks = 0;
  int          errors = 0;
  typedef struct {logic [31:0] busy; logic [2:0] cnt; logic sp;} exp_t;
  exp_t        q[$];
  fpu_ss_scoreboard dut (
    .clk_i(clk), .rst_ni(rst_ni), .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .rs1_i(rs1), .rs2_i(rs2), .rs3_i(rs3), .rs_used_i(rs_used), .rd_i(rd),
    .rd_is_fp_i(rd_is_fp), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .flush_i(flush),
    .busy_o(busy), .inflight_cnt_o(cnt), .hazard_o(hazard), .spurious_wb_o(spurious)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] r3, input logic [2:0] u, input logic [4:0] d,
                     input logic fp, input logic wv, input logic [4:0] wr, input logic fl);
    issue_valid = v; rs1 = r1; rs2 = r2; rs3 = r3; rs_used = u;
    rd = d; rd_is_fp = fp; wb_valid = wv; wb_rd = wr; flush = fl;
  endtask
  task automatic idle();
    drv(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
  endtask
  task automatic issue(input logic [4:0] d);
    drv(1, 0, 0, 0, 3'b000, d, 1, 0, 0, 0);
  endtask
  task automatic wb(input logic [4:0] r);
    drv(0, 0, 0, 0, 3'b000, 0, 0, 1, r, 0);
  endtask
  task automatic cyc(input string tag, input logic rdy, input logic haz,
                     input logic [31:0] eb, input logic [2:0] ec, input logic es);
    exp_t e;
    #1;
    chk({tag, ".ready"}, 32'(issue_ready), 32'(rdy));
    chk({tag, ".hazard"}, 32'(hazard), 32'(haz));
    q.push_back('{busy: eb, cnt: ec, sp: es});
    @(posedge clk);
    #1;
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, ".busy"}, busy, e.busy);
      chk({tag, ".cnt"}, 32'(cnt), 32'(e.cnt));
      chk({tag, ".spurious"}, 32'(spurious), 32'(e.sp));
    end
  endtask
  initial begin
    idle();
    #12;
    chk("reset.busy", busy, 32'h0);
    chk("reset.cnt", 32'(cnt), 32'h0);
    chk("reset.spurious", 32'(spurious), 32'h0);
    chk("reset.hazard", 32'(hazard), 32'h0);
    chk("reset.ready", 32'(issue_ready), 32'h1);
    #1 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    drv(1, 2, 3, 0, 3'b011, 1, 1, 0, 0, 0);
    cyc("f1_f2_f3", 1, 0, 32'h2, 1, 0);
    issue(5);
    cyc("issue_f5", 1, 0, 32'h22, 2, 0);
    drv(1, 5, 0, 0, 3'b001, 8, 1, 0, 0, 0);
    cyc("raw_blk0", 0, 1, 32'h22, 2, 0);
    cyc("raw_blk1", 0, 1, 32'h22, 2, 0);
    drv(1, 5, 0, 0, 3'b001, 8, 1, 1, 5, 0);
    cyc("raw_wb_cycle", 0, 1, 32'h02, 1, 0);
    drv(1, 5, 0, 0, 3'b001, 8, 1, 0, 0, 0);
    cyc("raw_release", 1, 0, 32'h102, 2, 0);
    drv(1, 0, 0, 0, 3'b000, 8, 1, 0, 0, 0);
    cyc("waw_blk", 0, 1, 32'h102, 2, 0);
    wb(1);
    cyc("wb_f1", 1, 0, 32'h100, 1, 0);
    wb(8);
    cyc("wb_f8", 1, 0, 32'h0, 0, 0);
    issue(1); cyc("fill1", 1, 0, 32'h02, 1, 0);
    issue(2); cyc("fill2", 1, 0, 32'h06, 2, 0);
    issue(3); cyc("fill3", 1, 0, 32'h0E, 3, 0);
    issue(4); cyc("fill4", 1, 0, 32'h1E, 4, 0);
    issue(6); cyc("full_blk", 0, 0, 32'h1E, 4, 0);
    drv(1, 6, 0, 0, 3'b001, 0, 0, 0, 0, 0);
    cyc("full_store", 1, 0, 32'h1E, 4, 0);
    drv(1, 0, 0, 0, 3'b000, 6, 1, 1, 2, 0);
    cyc("full_wb_f2", 0, 0, 32'h1A, 3, 0);
    issue(6); cyc("full_release", 1, 0, 32'h5A, 4, 0);
    wb(1); cyc("wb_f1b", 1, 0, 32'h58, 3, 0);
    drv(1, 0, 0, 0, 3'b000, 7, 1, 1, 3, 0);
    cyc("issue7_wb3", 1, 0, 32'hD0, 3, 0);
    wb(4); cyc("wb_f4", 1, 0, 32'hC0, 2, 0);
    wb(6); cyc("wb_f6", 1, 0, 32'h80, 1, 0);
    wb(7); cyc("wb_f7", 1, 0, 32'h0, 0, 0);
    issue(0); cyc("fl_fill0", 1, 0, 32'h01, 1, 0);
    issue(1); cyc("fl_fill1", 1, 0, 32'h03, 2, 0);
    issue(2); cyc("fl_fill2", 1, 0, 32'h07, 3, 0);
    issue(3); cyc("fl_fill3", 1, 0, 32'h0F, 4, 0);
    drv(1, 0, 0, 0, 3'b000, 5, 1, 1, 9, 1);
    cyc("flush", 0, 0, 32'h0, 0, 0);
    issue(5); cyc("post_flush", 1, 0, 32'h20, 1, 0);
    wb(5); cyc("wb_f5", 1, 0, 32'h0, 0, 0);
    wb(9); cyc("spurious_f9", 1, 0, 32'h0, 0, 1);
    idle(); cyc("spurious_sticky", 1, 0, 32'h0, 0, 1);
    issue(1); cyc("pre_reset", 1, 0, 32'h2, 1, 1);
    idle();
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst.busy", busy, 32'h0);
    chk("async_rst.cnt", 32'(cnt), 32'h0);
    chk("async_rst.spurious", 32'(spurious), 32'h0);
    chk("async_rst.ready", 32'(issue_ready), 32'h1);
    chk("async_rst.hazard", 32'(hazard), 32'h0);
    #2 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    wb(1); cyc("late_wb_spurious", 1, 0, 32'h0, 0, 1);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
